// File: rtl/mem_access_controller_pkg.sv
// Shared M-stage definitions: control-bit positions and the memory-access FSM
// state encoding used by the data-memory sequencer.
package pipeline_pkg;

   localparam int unsigned CTRL_REGWRITE = 2;
   localparam int unsigned CTRL_MEMTOREG = 1;
   localparam int unsigned CTRL_MEMWRITE = 0;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [1:0] FAULT = 2'd3;

   // A load or store carried by a real (non-bubble) instruction.
   function automatic logic is_mem_access(input logic valid, input logic [2:0] ctrls);
      return valid & (ctrls[CTRL_MEMTOREG] | ctrls[CTRL_MEMWRITE]);
   endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Data-memory req/ack port; master is the access controller, slave the memory.
interface mem_access_controller_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_access_controller_timeout.sv
// Wait-cycle counter for an outstanding memory request; flags the cycle in
// which the TIMEOUT-th unacknowledged request cycle is being spent.
module mem_timeout_counter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_count <= '0;
      else if (i_clear)
         r_count <= '0;
      else if (i_enable)
         r_count <= r_count + 1'b1;
   end

   // Compare against TIMEOUT-1 so the count reaches TIMEOUT on this very edge.
   assign o_expired = (r_count == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_controller.sv
// M-stage data-memory sequencer: issues req/ack accesses, stalls the pipeline
// while they are outstanding, returns load data and flags alignment/timeout faults.
module mem_access_controller
   import pipeline_pkg::*;
#(
   parameter int unsigned TIMEOUT     = 255,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           valid_m,
   input  logic [2:0]                     ctrls_m,
   input  logic [31:0]                    aluout_m,
   input  logic [31:0]                    writedata_m,
   mem_access_controller_if.master        mem,
   output logic [31:0]                    readdata_m,
   output logic                           stall_m,
   output logic                           bubble_w,
   output logic                           fault,
   output logic [31:0]                    fault_addr
);

   logic [1:0]  r_state;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_readdata;
   logic        r_fault;
   logic [31:0] r_fault_addr;

   logic        w_access;
   logic        w_misaligned;
   logic        w_in_req;
   logic        w_expired;
   logic        w_stall;

   assign w_access     = is_mem_access(valid_m, ctrls_m);
   assign w_misaligned = ALIGN_CHECK && (aluout_m[1:0] != 2'b00);
   assign w_in_req     = (r_state == REQ);

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (~w_in_req | mem.mem_ack),
      .i_enable  (w_in_req & ~mem.mem_ack),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_readdata   <= '0;
         r_fault      <= 1'b0;
         r_fault_addr <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  if (w_misaligned) begin
                     r_fault      <= 1'b1;
                     r_fault_addr <= aluout_m;
                     r_state      <= FAULT;
                  end else begin
                     r_mem_addr  <= aluout_m;
                     r_mem_wdata <= writedata_m;
                     r_mem_we    <= ctrls_m[CTRL_MEMWRITE];
                     r_mem_req   <= 1'b1;
                     r_state     <= REQ;
                  end
               end
            end
            REQ: begin
               // Ack is checked first so a same-cycle ack beats the timeout.
               if (mem.mem_ack) begin
                  if (!r_mem_we)
                     r_readdata <= mem.mem_rdata;
                  r_mem_req <= 1'b0;
                  r_state   <= DONE;
               end else if (w_expired) begin
                  r_mem_req    <= 1'b0;
                  r_fault      <= 1'b1;
                  r_fault_addr <= r_mem_addr;
                  r_state      <= FAULT;
               end
            end
            DONE:    r_state <= IDLE;
            FAULT:   r_state <= FAULT;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         IDLE:    w_stall = w_access;
         REQ:     w_stall = 1'b1;
         FAULT:   w_stall = 1'b1;
         default: w_stall = 1'b0;
      endcase
      if (reset)
         w_stall = 1'b0;
   end

   assign stall_m       = w_stall;
   assign bubble_w      = w_stall;
   assign readdata_m    = r_readdata;
   assign fault         = r_fault;
   assign fault_addr    = r_fault_addr;
   assign mem.mem_req   = r_mem_req;
   assign mem.mem_we    = r_mem_we;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wdata = r_mem_wdata;

endmodule
